// File: rtl/seg_scanner.sv
// Four-digit multiplexed seven-segment driver: shadows the BCD digits on update
// and scans them onto active-low anode/segment lines with optional zero blanking.
module seg_scanner #(
  parameter int unsigned SCAN_CYCLES = 50000,
  parameter int unsigned CNT_W       = 16
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       update,
  input  logic [3:0] bcd0,
  input  logic [3:0] bcd1,
  input  logic [3:0] bcd2,
  input  logic [3:0] bcd3,
  input  logic       lzb_en,
  input  logic       blank,
  output logic [3:0] an,
  output logic [6:0] seg
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_CYCLES - 32'd1);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        idx_q, idx_d;
  logic [3:0][3:0]   sh_q, sh_d;
  logic [3:0]        an_q, an_d;
  logic [6:0]        seg_q, seg_d;
  logic              tick;
  logic              lead_zero;
  logic              dig_off;
  logic [3:0]        sel_digit;

  function automatic logic [6:0] decode_seg(input logic [3:0] v);
    logic [6:0] p;
    case (v)
      4'd0:    p = 7'b1000000;
      4'd1:    p = 7'b1111001;
      4'd2:    p = 7'b0100100;
      4'd3:    p = 7'b0110000;
      4'd4:    p = 7'b0011001;
      4'd5:    p = 7'b0010010;
      4'd6:    p = 7'b0000010;
      4'd7:    p = 7'b1111000;
      4'd8:    p = 7'b0000000;
      4'd9:    p = 7'b0010000;
      default: p = 7'b0111111;
    endcase
    return p;
  endfunction

  // Next-state for prescaler, digit index, shadows, and the output register.
  always_comb begin
    tick      = (cnt_q == CNT_LAST);
    cnt_d     = tick ? {CNT_W{1'b0}} : cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    idx_d     = tick ? idx_q + 2'd1 : idx_q;
    sh_d      = update ? {bcd3, bcd2, bcd1, bcd0} : sh_q;
    sel_digit = sh_q[idx_q];

    // A digit is a leading zero when it and every digit above it are zero.
    case (idx_q)
      2'd1:    lead_zero = (sh_q[1] == 4'd0) && (sh_q[2] == 4'd0) && (sh_q[3] == 4'd0);
      2'd2:    lead_zero = (sh_q[2] == 4'd0) && (sh_q[3] == 4'd0);
      2'd3:    lead_zero = (sh_q[3] == 4'd0);
      default: lead_zero = 1'b0;
    endcase

    dig_off = blank | (lzb_en & lead_zero);
    if (dig_off) begin
      an_d  = 4'b1111;
      seg_d = 7'h7F;
    end else begin
      an_d  = ~(4'b0001 << idx_q);
      seg_d = decode_seg(sel_digit);
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      cnt_q <= {CNT_W{1'b0}};
      idx_q <= 2'd0;
      sh_q  <= {4{4'd0}};
      an_q  <= 4'b1111;
      seg_q <= 7'h7F;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      sh_q  <= sh_d;
      an_q  <= an_d;
      seg_q <= seg_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;

endmodule

// File: tb/tb_seg_scanner.sv
// Bench for seg_scanner: a cycle-count based display model checked every cycle,
// plus hand-computed literal expectations at chosen scan positions.
module tb_seg_scanner;

  localparam int unsigned SCAN = 4;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       update;
  logic [3:0] bcd0, bcd1, bcd2, bcd3;
  logic       lzb_en;
  logic       blank;
  logic [3:0] an;
  logic [6:0] seg;

  int vectors    = 0;
  int miscompares = 0;

  seg_scanner #(.SCAN_CYCLES(SCAN), .CNT_W(16)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .update(update),
    .bcd0  (bcd0),
    .bcd1  (bcd1),
    .bcd2  (bcd2),
    .bcd3  (bcd3),
    .lzb_en(lzb_en),
    .blank (blank),
    .an    (an),
    .seg   (seg)
  );

  always #5 Clock = ~Clock;

  localparam logic [6:0] SEG_TAB [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
    7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111
  };

  // Model: n = edges since reset; the selected digit is (n / SCAN) mod 4.
  int unsigned     m_n;
  logic [3:0][3:0] m_sh;
  logic            m_valid = 1'b0;
  logic [3:0]      exp_an;
  logic [6:0]      exp_seg;

  function automatic logic [10:0] model_out(input int unsigned n, input logic [3:0][3:0] sh,
                                            input logic lzb, input logic blk);
    int d;
    int msd;
    d   = int'((n / SCAN) % 4);
    msd = 0;
    for (int k = 0; k < 4; k++)
      if (sh[k] != 4'd0) msd = k;
    if (blk || (lzb && d > msd))
      return {4'b1111, 7'h7F};
    return {~(4'b0001 << d), SEG_TAB[sh[d]]};
  endfunction

  always @(posedge Clock) begin
    if (Reset) begin
      m_n     <= 0;
      m_sh    <= '0;
      exp_an  <= 4'b1111;
      exp_seg <= 7'h7F;
    end else begin
      {exp_an, exp_seg} <= model_out(m_n, m_sh, lzb_en, blank);
      m_n <= m_n + 1;
      if (update) m_sh <= {bcd3, bcd2, bcd1, bcd0};
    end
    m_valid <= 1'b1;
  end

  always @(negedge Clock) begin
    if (m_valid) begin
      vectors++;
      if (an !== exp_an || seg !== exp_seg) begin
        miscompares++;
        $display("FAIL model t=%0t: an=%b seg=%b, expected an=%b seg=%b",
                 $time, an, seg, exp_an, exp_seg);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  task automatic check_lit(input string name, input logic [3:0] e_an, input logic [6:0] e_seg);
    vectors++;
    if (an !== e_an || seg !== e_seg) begin
      miscompares++;
      $display("FAIL %s: an=%b seg=%b, expected an=%b seg=%b", name, an, seg, e_an, e_seg);
    end
  endtask

  task automatic set_bcd(input logic [3:0] d3, input logic [3:0] d2,
                         input logic [3:0] d1, input logic [3:0] d0);
    bcd3 = d3; bcd2 = d2; bcd1 = d1; bcd0 = d0;
  endtask

  initial begin
    Reset = 1'b1; update = 1'b0; lzb_en = 1'b0; blank = 1'b0;
    set_bcd(4'd0, 4'd0, 4'd0, 4'd0);

    // Reset and plain scan
    step(2);
    check_lit("reset_dark", 4'b1111, 7'h7F);
    Reset = 1'b0;
    step(1);  check_lit("first_cycle", 4'b1110, 7'b1000000);
    step(4);  check_lit("scan_d1", 4'b1101, 7'b1000000);
    step(4);  check_lit("scan_d2", 4'b1011, 7'b1000000);
    step(4);  check_lit("scan_d3", 4'b0111, 7'b1000000);
    step(4);  check_lit("scan_wrap", 4'b1110, 7'b1000000);

    // Capture 1234, then change bcd without update
    set_bcd(4'd1, 4'd2, 4'd3, 4'd4); update = 1'b1;
    step(1);
    update = 1'b0; set_bcd(4'd9, 4'd9, 4'd9, 4'd9);
    step(1);  check_lit("dec_d0_4", 4'b1110, 7'b0011001);
    step(2);  check_lit("dec_d1_3", 4'b1101, 7'b0110000);
    step(4);  check_lit("dec_d2_2", 4'b1011, 7'b0100100);
    step(4);  check_lit("dec_d3_1", 4'b0111, 7'b1111001);

    // Leading-zero blanking on 0070
    lzb_en = 1'b1; set_bcd(4'd0, 4'd0, 4'd7, 4'd0); update = 1'b1;
    step(1);
    update = 1'b0;
    step(3);  check_lit("lzb_d0", 4'b1110, 7'b1000000);
    step(4);  check_lit("lzb_d1", 4'b1101, 7'b1111000);
    step(4);  check_lit("lzb_d2_off", 4'b1111, 7'h7F);
    step(4);  check_lit("lzb_d3_off", 4'b1111, 7'h7F);

    // All zero: only digit 0 lit
    set_bcd(4'd0, 4'd0, 4'd0, 4'd0); update = 1'b1;
    step(1);
    update = 1'b0;
    step(3);  check_lit("zero_d0", 4'b1110, 7'b1000000);
    step(4);  check_lit("zero_d1_off", 4'b1111, 7'h7F);

    // Dash in thousands digit keeps everything lit
    set_bcd(4'd12, 4'd0, 4'd0, 4'd0); update = 1'b1;
    step(1);
    update = 1'b0;
    step(4);  check_lit("dash_d2", 4'b1011, 7'b1000000);
    step(4);  check_lit("dash_d3", 4'b0111, 7'b0111111);

    // Blank for 10 cycles, scan position preserved
    blank = 1'b1;
    step(10); check_lit("blank_on", 4'b1111, 7'h7F);
    blank = 1'b0;
    step(1);  check_lit("blank_release", 4'b1011, 7'b1000000);

    // Update on the tick edge
    step(2);
    set_bcd(4'd8, 4'd7, 4'd6, 4'd5); update = 1'b1;
    step(1);  check_lit("tick_upd_old", 4'b1011, 7'b1000000);
    update = 1'b0;
    step(1);  check_lit("tick_upd_new", 4'b0111, 7'b0000000);

    // Reset wins over update
    Reset = 1'b1; update = 1'b1; set_bcd(4'd9, 4'd9, 4'd9, 4'd9);
    step(1);  check_lit("reset_upd", 4'b1111, 7'h7F);
    Reset = 1'b0; update = 1'b0;
    step(1);  check_lit("post_reset_d0", 4'b1110, 7'b1000000);
    step(4);  check_lit("post_reset_d1_off", 4'b1111, 7'h7F);
    step(8);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seg_scanner.md
# seg_scanner

Time-multiplexed 4-digit seven-segment driver that sits directly downstream of the binary-to-BCD output divider. It captures the four BCD digits on an `update` strobe into shadow registers, so a conversion still in progress never tears the display. It then scans one digit at a time onto shared active-low segment and anode lines, with optional leading-zero blanking. The display controller pulses `update` once the divider has finished, at least 5 cycles after its `load`.

## Interface
- `SCAN_CYCLES`, default 50000: clock cycles each digit stays lit; legal range 1..2^`CNT_W`-1.
- `CNT_W`, default 16: width of the prescale counter.
- `Clock` input, 1 bit: the single clock; every register updates on its rising edge.
- `Reset` input, 1 bit: synchronous, active-high reset.
- `update` input, 1 bit: on a cycle where it is 1, `bcd0`..`bcd3` are copied into the shadow registers.
- `bcd0` input, 4 bits: ones digit (least significant).
- `bcd1` input, 4 bits: tens digit.
- `bcd2` input, 4 bits: hundreds digit.
- `bcd3` input, 4 bits: thousands digit (most significant).
- `lzb_en` input, 1 bit: 1 enables leading-zero blanking.
- `blank` input, 1 bit: 1 turns all digits off; scanning continues underneath.
- `an` output, 4 bits: active-low anode enables; `an[k]` drives digit k.
- `seg` output, 7 bits: active-low segments, ordered {g,f,e,d,c,b,a}.

## Operation
**Reset** (`Reset`=1 at an edge):
- prescale counter `cnt`=0, digit index `idx`=0, shadows `sh0`..`sh3`=0.
- `an`=4'b1111, `seg`=7'h7F (everything dark).
- Reset has priority over `update` and over the scan logic.

**Prescaler:**
- `cnt` counts 0..`SCAN_CYCLES`-1, then wraps to 0.
- `tick` = (`cnt`==`SCAN_CYCLES`-1).
- On `tick`, `idx` advances 0→1→2→3→0.
- With `SCAN_CYCLES`=1, `idx` advances every cycle.

**Capture:**
- When `update`=1, `shk` <= `bcdk` for all four digits in the same edge.
- The shadows are otherwise held. `bcd*` inputs are ignored when `update`=0.

**Blanking of digit k** (evaluated for the currently selected digit):
- Digit 0 is never leading-zero blanked.
- Digit k (k=1..3) is blanked when `lzb_en`=1, `shk`==0, and every shadow digit above k is also 0.
- `blank`=1 overrides everything: `an`=4'b1111, `seg`=7'h7F.

**Output register:** every cycle, `an` and `seg` are loaded from the current `idx`, shadows, `lzb_en` and `blank`:
- `an` = all ones except bit `idx`, which is 0. If the digit is blanked, `an` is 4'b1111.
- `seg` is the decoded pattern of `sh[idx]`, or 7'h7F when the digit is blanked.

**Decode** (active low, {g,f,e,d,c,b,a}):
- 0=1000000
- 1=1111001
- 2=0100100
- 3=0110000
- 4=0011001
- 5=0010010
- 6=0000010
- 7=1111000
- 8=0000000
- 9=0010000
- 10..15 = dash 0111111. A dash digit counts as non-zero for blanking.

## Timing
- **Output latency:** `an`/`seg` lag any change of `idx`, shadow, `lzb_en` or `blank` by exactly 1 cycle.
- **After reset release:** on the first edge, the outputs show digit 0 with value 0 (`an`=1110, `seg`=1000000). `idx` first advances at edge `SCAN_CYCLES`.
- **Steady state:** each digit is driven for exactly `SCAN_CYCLES` consecutive cycles; one full refresh takes 4·`SCAN_CYCLES` cycles.
- **`update` and `tick` in the same edge:** both take effect. The next cycle shows the new `idx` using the new shadows.
- **`update` held high across cycles:** the shadows track `bcd*` on every edge.
- **Reset mid-scan:** the next cycle is the full reset state. Prior shadows are lost.
- **Wrap-around:** `idx` 3→0 and `cnt` wrap with no dead cycle. `an` never has more than one 0 bit.

## Test plan
All scenarios use `SCAN_CYCLES`=4.

1. **Reset:** assert `Reset` for 2 cycles, then release → `an`=1111 and `seg`=7F during reset. The first post-reset cycle shows `an`=1110, `seg`=1000000. `an` then steps 1101, 1011, 0111, 1110 every 4 cycles.
2. **Capture and decode:** `update` pulse with bcd3..0=1,2,3,4, `lzb_en`=0 → digits 0..3 show 0011001, 0110000, 0100100, 1111001. Changing `bcd*` afterwards without `update` leaves the display unchanged.
3. **Leading-zero blanking:** `lzb_en`=1, value 0,0,7,0 (bcd3..0) → digit 3 and digit 2 have `an`=1111, `seg`=7F. Digit 1 shows 1111000 and digit 0 shows 1000000. Value 0,0,0,0 → only digit 0 lit, showing "0".
4. **Dash:** `bcd3`=12 with the other digits 0 and `lzb_en`=1 → digit 3 shows 0111111 and no digit is blanked.
5. **`blank`:** assert `blank` for 10 cycles → `an`=1111 throughout. On release the scan resumes at the `idx` implied by the uninterrupted prescaler.
6. **Simultaneous and reset corners:** `update` on the `tick` edge → the new digit appears with the new value 1 cycle later. `Reset` together with `update` → reset wins and the shadows stay 0.
